// File: rtl/pkg_unpack.sv
// ---------------------------------------------------------------------------
// pkg_unpack
//
// Receive side of the package link. Parses the 16-bit package word stream,
// checks the framing header, the destination device id, the payload length
// and the trailing checksum. It then forwards the payload onto a chip-path
// style bus for downstream per-chip logic.
//
// Frame layout (one word per pkg_vld):
//   W0 = SYNC_WORD
//   W1 = {dev_id[5:0], chip_sel[6:0], 3'b000}
//   W2 = {12'h000, len[19:16]}
//   W3 = len[15:0]
//   len payload words
//   checksum word = 16-bit wrap-around sum of the payload words
//
// Every frame that gets past W0 ends with a one-cycle pkg_done pulse.
// Exactly one of pkt_ok / pkt_drop / pkt_err accompanies that pulse.
//
// Ports:
//   clk_sys   in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   pluse_us  in   1   one-cycle tick every microsecond (timeout time base)
//   dev_id    in   6   this device's id
//   pkg_d     in  16   package word
//   pkg_vld   in   1   pkg_d valid this cycle (no backpressure)
//   pkg_done  out  1   one-cycle pulse at frame end
//   chip_d    out 16   forwarded payload word
//   chip_vld  out  1   chip_d valid (one cycle after the payload word)
//   chip_sel  out  7   chip select from the header, held for the frame
//   chip_len  out 20   payload length from the header, held for the frame
//   pkt_ok    out  1   with pkg_done: frame for us, checksum good
//   pkt_drop  out  1   with pkg_done: frame for another device, checksum good
//   pkt_err   out  1   with pkg_done: bad length, bad checksum or timeout
// ---------------------------------------------------------------------------
module pkg_unpack #(
   parameter logic [15:0] SYNC_WORD  = 16'hEB90,
   parameter logic [19:0] MAX_LEN    = 20'd65536,
   parameter logic [15:0] TIMEOUT_US = 16'd1000
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        pluse_us,
   input  logic [5:0]  dev_id,
   input  logic [15:0] pkg_d,
   input  logic        pkg_vld,
   output logic        pkg_done,
   output logic [15:0] chip_d,
   output logic        chip_vld,
   output logic [6:0]  chip_sel,
   output logic [19:0] chip_len,
   output logic        pkt_ok,
   output logic        pkt_drop,
   output logic        pkt_err
);

   typedef enum logic [2:0] {
      ST_IDLE,   // hunting for SYNC_WORD
      ST_HDR,    // expecting W1 (device id / chip select)
      ST_LENH,   // expecting W2 (upper length nibble)
      ST_LENL,   // expecting W3 (lower length half)
      ST_DATA,   // payload words
      ST_CSUM,   // checksum word
      ST_ERR     // one cycle of error signalling, input discarded
   } state_t;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t      state,     state_nxt;
   logic        match,     match_nxt;      // W1 id equals dev_id
   logic [3:0]  len_hi,    len_hi_nxt;     // len[19:16] held until W3
   logic [19:0] rem,       rem_nxt;        // payload words still expected
   logic [15:0] acc,       acc_nxt;        // running payload sum
   logic [15:0] tmo_cnt,   tmo_cnt_nxt;    // pluse_us ticks since last word

   // Next values of the registered outputs
   logic        pkg_done_nxt;
   logic [15:0] chip_d_nxt;
   logic        chip_vld_nxt;
   logic [6:0]  chip_sel_nxt;
   logic [19:0] chip_len_nxt;
   logic        pkt_ok_nxt;
   logic        pkt_drop_nxt;
   logic        pkt_err_nxt;

   logic        timeout_hit;
   logic        frame_err;
   logic [19:0] len_full;

   // Full payload length as it becomes known on W3
   assign len_full = {len_hi, pkg_d};

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement so
      // that no path leaves one unassigned; otherwise a latch is inferred.
      state_nxt    = state;
      match_nxt    = match;
      len_hi_nxt   = len_hi;
      rem_nxt      = rem;
      acc_nxt      = acc;
      tmo_cnt_nxt  = tmo_cnt;
      pkg_done_nxt = 1'b0;
      chip_d_nxt   = chip_d;
      chip_vld_nxt = 1'b0;
      chip_sel_nxt = chip_sel;
      chip_len_nxt = chip_len;
      pkt_ok_nxt   = 1'b0;
      pkt_drop_nxt = 1'b0;
      pkt_err_nxt  = 1'b0;
      timeout_hit  = 1'b0;
      frame_err    = 1'b0;

      // Idle-gap watchdog. It runs only while a frame is open. Any word
      // restarts it, and a tick in the same cycle as a word is ignored.
      if (state == ST_IDLE || state == ST_ERR) begin
         tmo_cnt_nxt = '0;
      end else if (pkg_vld) begin
         tmo_cnt_nxt = '0;
      end else if (pluse_us) begin
         if ({1'b0, tmo_cnt} + 17'd1 >= {1'b0, TIMEOUT_US}) begin
            timeout_hit = 1'b1;
            tmo_cnt_nxt = '0;
         end else begin
            tmo_cnt_nxt = tmo_cnt + 16'd1;
         end
      end

      unique case (state)
         ST_IDLE: begin
            if (pkg_vld && pkg_d == SYNC_WORD) begin
               acc_nxt   = '0;
               state_nxt = ST_HDR;
            end
         end

         ST_HDR: begin
            if (pkg_vld) begin
               chip_sel_nxt = pkg_d[9:3];
               match_nxt    = (pkg_d[15:10] == dev_id);
               state_nxt    = ST_LENH;
            end
         end

         ST_LENH: begin
            if (pkg_vld) begin
               if (pkg_d[15:4] != 12'h000) begin
                  frame_err = 1'b1;
               end else begin
                  len_hi_nxt = pkg_d[3:0];
                  state_nxt  = ST_LENL;
               end
            end
         end

         ST_LENL: begin
            if (pkg_vld) begin
               chip_len_nxt = len_full;
               if (len_full > MAX_LEN) begin
                  frame_err = 1'b1;
               end else if (len_full == 20'd0) begin
                  state_nxt = ST_CSUM;
               end else begin
                  rem_nxt   = len_full;
                  state_nxt = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            // SYNC_WORD is ordinary data here: there is no mid-frame resync.
            if (pkg_vld) begin
               acc_nxt = acc + pkg_d;
               rem_nxt = rem - 20'd1;
               if (match) begin
                  chip_d_nxt   = pkg_d;
                  chip_vld_nxt = 1'b1;
               end
               if (rem == 20'd1) begin
                  state_nxt = ST_CSUM;
               end
            end
         end

         ST_CSUM: begin
            if (pkg_vld) begin
               if (pkg_d != acc) begin
                  frame_err = 1'b1;
               end else begin
                  pkg_done_nxt = 1'b1;
                  pkt_ok_nxt   = match;
                  pkt_drop_nxt = ~match;
                  state_nxt    = ST_IDLE;
               end
            end
         end

         ST_ERR: begin
            // The error pulse is already on the outputs. This cycle only
            // swallows whatever arrives, then the parser re-arms.
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A length or checksum fault and a timeout cannot coincide, because
      // the timeout only fires on cycles without a word. Both are
      // signalled the same way.
      if (frame_err || timeout_hit) begin
         pkg_done_nxt = 1'b1;
         pkt_err_nxt  = 1'b1;
         state_nxt    = ST_ERR;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every
   // register then samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         match    <= 1'b0;
         len_hi   <= '0;
         rem      <= '0;
         acc      <= '0;
         tmo_cnt  <= '0;
         pkg_done <= 1'b0;
         chip_d   <= '0;
         chip_vld <= 1'b0;
         chip_sel <= '0;
         chip_len <= '0;
         pkt_ok   <= 1'b0;
         pkt_drop <= 1'b0;
         pkt_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         match    <= match_nxt;
         len_hi   <= len_hi_nxt;
         rem      <= rem_nxt;
         acc      <= acc_nxt;
         tmo_cnt  <= tmo_cnt_nxt;
         pkg_done <= pkg_done_nxt;
         chip_d   <= chip_d_nxt;
         chip_vld <= chip_vld_nxt;
         chip_sel <= chip_sel_nxt;
         chip_len <= chip_len_nxt;
         pkt_ok   <= pkt_ok_nxt;
         pkt_drop <= pkt_drop_nxt;
         pkt_err  <= pkt_err_nxt;
      end
   end

endmodule
